// File: rtl/mpi_rx_bridge_pkg.sv
// Shared types for the MPI receive bridge, plus the SV-side link endpoint behind
// the MPI calls: a scripted queue of incoming flits and a per-call log.
package mpi_bridge_pkg;
  localparam int DATA_W_DEFAULT = 64;

  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, DONE = 2'd2} rx_state_e;

  typedef struct packed {
    logic        vld;
    logic [63:0] data;
  } lnk_flit_t;

  // An empty script means the sender is idle (valid 0).
  lnk_flit_t lnk_script[$];
  lnk_flit_t lnk_cur;
  int lnk_n_recv, lnk_n_valid, lnk_n_send, lnk_n_send1, lnk_n_final;
  int lnk_last_src, lnk_last_dest, lnk_last_rank;

  function automatic logic [63:0] mpi_receive_data(input int origin);
    lnk_n_recv++;
    lnk_last_src = origin;
    lnk_cur = '0;
    if (lnk_script.size() != 0) lnk_cur = lnk_script.pop_front();
    return lnk_cur.data;
  endfunction

  function automatic byte mpi_get_valid();
    lnk_n_valid++;
    return {7'b0, lnk_cur.vld};
  endfunction

  function automatic void mpi_send_yummy(input byte valid, input int dest, input int rank);
    lnk_n_send++;
    if (valid != 8'd0) lnk_n_send1++;
    lnk_last_dest = dest;
    lnk_last_rank = rank;
  endfunction

  function automatic void finalize();
    lnk_n_final++;
  endfunction
endpackage

// File: rtl/mpi_rx_fifo.sv
// Flit FIFO whose push/pop are the ops decided on the previous edge; its outputs
// look through that pending op, so callers see the state as of just after it.
module mpi_rx_fifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int PW    = AW + 1
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] head_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [PW-1:0]     count_o
);
  logic [PW-1:0]     rptr_q, wptr_q, rptr_d, wptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  assign rptr_d  = rptr_q + PW'(pop_i);
  assign wptr_d  = wptr_q + PW'(push_i);
  assign count_o = wptr_d - rptr_d;
  assign empty_o = (count_o == '0);
  assign full_o  = (count_o == PW'(DEPTH));
  // The only live entry may still be the pending write.
  assign head_o  = (push_i && rptr_d == wptr_q) ? wdata_i : mem_q[rptr_d[AW-1:0]];

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rptr_q <= '0;
      wptr_q <= '0;
    end else begin
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end
endmodule

// File: rtl/mpi_rx_bridge.sv
// Receive end of the rank-to-rank MPI link: polls the sender each edge, buffers
// flits, and returns one yummy per edge (valid when a flit was consumed).
module mpi_rx_bridge
  import mpi_bridge_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEFAULT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic [31:0]       rank_i,
  input  logic [31:0]       origin_i,
  input  logic              finalize_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              yummy_o,
  output logic              full_o,
  output logic              overflow_o,
  output logic [31:0]       rx_count_o,
  output logic              done_o
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  rx_state_e         state_q;
  logic              push_q, pop_q, yummy_q, overflow_q;
  logic [DATA_W-1:0] wdata_q, head;
  logic [31:0]       rx_count_q;
  logic              full, empty, pop;
  logic [CW-1:0]     count;

  mpi_rx_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .push_i  (push_q),
    .pop_i   (pop_q),
    .wdata_i (wdata_q),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  assign valid_o    = !empty && (state_q != DONE);
  assign pop        = valid_o && ready_i;
  assign data_o     = valid_o ? head : '0;
  assign full_o     = full;
  assign yummy_o    = yummy_q;
  assign overflow_o = overflow_q;
  assign rx_count_o = rx_count_q;
  assign done_o     = (state_q == DONE);

  // Link calls are made in call order inside the clocked process; the resulting
  // FIFO op is registered and committed by u_fifo on the next edge.
  always_ff @(posedge clk_i or negedge rstn_i) begin : p_link
    logic [63:0] rx_data;
    logic        rx_vld;
    logic        push;
    if (!rstn_i) begin
      state_q    <= RUN;
      push_q     <= 1'b0;
      pop_q      <= 1'b0;
      wdata_q    <= '0;
      yummy_q    <= 1'b0;
      overflow_q <= 1'b0;
      rx_count_q <= '0;
    end else if (state_q == DONE) begin
      push_q  <= 1'b0;
      pop_q   <= 1'b0;
      yummy_q <= 1'b0;
    end else begin
      rx_data = mpi_receive_data(int'(origin_i));
      rx_vld  = (mpi_get_valid() & 8'h01) != 8'h00;
      push    = rx_vld && (!full || pop);
      mpi_send_yummy({7'b0, pop}, int'(origin_i), int'(rank_i));
      push_q  <= push;
      pop_q   <= pop;
      wdata_q <= rx_data[DATA_W-1:0];
      yummy_q <= pop;
      if (push) rx_count_q <= rx_count_q + 32'd1;
      if (rx_vld && full && !pop) overflow_q <= 1'b1;
      if (state_q == RUN && finalize_i) begin
        state_q <= DRAIN;
      end else if (state_q == DRAIN && !rx_vld && count == CW'(pop)) begin
        finalize();
        state_q <= DONE;
      end
    end
  end

  // MPI cannot be re-entered once finalized.
  always @(negedge rstn_i) begin
    assert (state_q != DONE) else $error("mpi_rx_bridge: reset after finalize");
  end
endmodule

// File: tb/tb_mpi_rx_bridge.sv
// Self-checking bench for mpi_rx_bridge against a queue-level reference model.
module tb_mpi_rx_bridge;
  import mpi_bridge_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rstn_i = 1'b0;
  logic [31:0] rank_i = 32'd3;
  logic [31:0] origin_i = 32'd7;
  logic        finalize_i = 1'b0;
  logic [63:0] data_o;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic        yummy_o, full_o, overflow_o, done_o;
  logic [31:0] rx_count_o;

  int errs = 0;
  int checks = 0;

  // Reference model
  logic [63:0] m_q[$];
  int          m_cnt, m_y1, m_recv, m_fin, m_phase;
  logic        m_ovf, m_yum;

  always #5 clk = ~clk;

  mpi_rx_bridge #(.DATA_W(64), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rstn_i(rstn_i), .rank_i(rank_i), .origin_i(origin_i),
    .finalize_i(finalize_i), .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
    .yummy_o(yummy_o), .full_o(full_o), .overflow_o(overflow_o),
    .rx_count_o(rx_count_o), .done_o(done_o)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic model_clear();
    m_q.delete();
    m_cnt = 0; m_y1 = 0; m_recv = 0; m_fin = 0; m_phase = 0;
    m_ovf = 1'b0; m_yum = 1'b0;
    lnk_script.delete();
    lnk_n_recv = 0; lnk_n_valid = 0; lnk_n_send = 0; lnk_n_send1 = 0; lnk_n_final = 0;
  endtask

  task automatic do_reset();
    rstn_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_clear();
    rstn_i = 1'b1;
  endtask

  // Script the sender for the next edge, advance the model, take the edge.
  task automatic tick(input logic v, input logic [63:0] d);
    logic pop, push;
    if (m_phase != 2) begin
      lnk_script.push_back({v, d});
      pop  = (m_q.size() != 0) && ready_i;
      push = v && ((m_q.size() < DEPTH) || pop);
      m_recv++;
      if (pop) begin m_y1++; void'(m_q.pop_front()); end
      if (push) begin m_q.push_back(d); m_cnt++; end
      if (v && !push) m_ovf = 1'b1;
      m_yum = pop;
      if (m_phase == 0 && finalize_i) m_phase = 1;
      else if (m_phase == 1 && m_q.size() == 0 && !v) begin m_phase = 2; m_fin++; end
    end else begin
      m_yum = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (5) @(posedge clk);
    #1;
    checks++; if ({data_o, valid_o, yummy_o, full_o, overflow_o, rx_count_o, done_o} !== '0) begin
      errs++; $display("FAIL reset_outputs: got data=%0h v=%0b y=%0b f=%0b o=%0b c=%0d d=%0b want all 0",
                       data_o, valid_o, yummy_o, full_o, overflow_o, rx_count_o, done_o); end
    checks++; if (lnk_n_recv + lnk_n_valid + lnk_n_send + lnk_n_final !== 0) begin
      errs++; $display("FAIL reset_no_calls: got %0d calls want 0", lnk_n_recv + lnk_n_valid + lnk_n_send); end
    model_clear();
    rstn_i = 1'b1;
    tick(1'b0, 64'd0);
    checks++; if (lnk_n_recv !== 1 || lnk_n_valid !== 1 || lnk_n_send !== 1) begin
      errs++; $display("FAIL first_cycle_calls: got recv=%0d valid=%0d send=%0d want 1/1/1",
                       lnk_n_recv, lnk_n_valid, lnk_n_send); end
    checks++; if (lnk_last_src !== 7 || lnk_last_dest !== 7 || lnk_last_rank !== 3) begin
      errs++; $display("FAIL call_args: got src=%0d dest=%0d rank=%0d want 7/7/3",
                       lnk_last_src, lnk_last_dest, lnk_last_rank); end
  endtask

  task automatic test_single();
    ready_i = 1'b1;
    tick(1'b1, 64'h0000_0000_DEAD_BEEF);
    checks++; if (valid_o !== 1'b1 || data_o !== 64'h0000_0000_DEAD_BEEF) begin
      errs++; $display("FAIL single_data: got v=%0b d=%0h want 1 deadbeef", valid_o, data_o); end
    checks++; if (rx_count_o !== 32'd1 || lnk_n_send1 !== 0) begin
      errs++; $display("FAIL single_count: got c=%0d y1=%0d want 1 0", rx_count_o, lnk_n_send1); end
    tick(1'b0, 64'd0);
    checks++; if (lnk_n_send1 !== 1 || yummy_o !== 1'b1 || valid_o !== 1'b0) begin
      errs++; $display("FAIL single_yummy: got y1=%0d y=%0b v=%0b want 1 1 0", lnk_n_send1, yummy_o, valid_o); end
  endtask

  task automatic test_overflow();
    do_reset();
    ready_i = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick(1'b1, 64'(i));
      if (i == 4) begin
        checks++; if (full_o !== 1'b1 || overflow_o !== 1'b0) begin
          errs++; $display("FAIL ovf_full4: got f=%0b o=%0b want 1 0", full_o, overflow_o); end
      end
    end
    checks++; if (overflow_o !== 1'b1 || rx_count_o !== 32'd4 || full_o !== 1'b1) begin
      errs++; $display("FAIL ovf_drop: got o=%0b c=%0d f=%0b want 1 4 1", overflow_o, rx_count_o, full_o); end
    ready_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      checks++; if (valid_o !== 1'b1 || data_o !== 64'(i)) begin
        errs++; $display("FAIL ovf_order: got v=%0b d=%0h want 1 %0h", valid_o, data_o, i); end
      tick(1'b0, 64'd0);
    end
    checks++; if (lnk_n_send1 !== 4 || valid_o !== 1'b0 || overflow_o !== 1'b1) begin
      errs++; $display("FAIL ovf_drain: got y1=%0d v=%0b o=%0b want 4 0 1", lnk_n_send1, valid_o, overflow_o); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    ready_i = 1'b0;
    for (int i = 0; i < 4; i++) tick(1'b1, 64'(100 + i));
    ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, {$urandom, $urandom});
      checks++; if (full_o !== 1'b1 || overflow_o !== 1'b0 || yummy_o !== 1'b1 || data_o !== m_q[0]) begin
        errs++; $display("FAIL b2b_cycle%0d: got f=%0b o=%0b y=%0b d=%0h want 1 0 1 %0h",
                         i, full_o, overflow_o, yummy_o, data_o, m_q[0]); end
    end
    checks++; if (rx_count_o !== 32'd14 || lnk_n_send1 !== 10 || lnk_n_send !== 14) begin
      errs++; $display("FAIL b2b_totals: got c=%0d y1=%0d s=%0d want 14 10 14", rx_count_o, lnk_n_send1, lnk_n_send); end
  endtask

  task automatic test_random();
    logic v;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      ready_i = ((i / 20) % 2 == 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      v = ($urandom_range(0, 2) != 0);
      tick(v, {$urandom, $urandom});
      checks++; if (valid_o !== (m_q.size() != 0) || (valid_o && data_o !== m_q[0])) begin
        errs++; $display("FAIL rand_head@%0d: got v=%0b d=%0h want v=%0b", i, valid_o, data_o, m_q.size() != 0); end
      checks++; if (full_o !== (m_q.size() == DEPTH) || overflow_o !== m_ovf || rx_count_o !== 32'(m_cnt)) begin
        errs++; $display("FAIL rand_status@%0d: got f=%0b o=%0b c=%0d want %0b %0b %0d",
                         i, full_o, overflow_o, rx_count_o, m_q.size() == DEPTH, m_ovf, m_cnt); end
      checks++; if (yummy_o !== m_yum || lnk_n_send1 !== m_y1 || lnk_n_recv !== m_recv || lnk_n_send !== m_recv) begin
        errs++; $display("FAIL rand_link@%0d: got y=%0b y1=%0d r=%0d s=%0d want %0b %0d %0d %0d",
                         i, yummy_o, lnk_n_send1, lnk_n_recv, lnk_n_send, m_yum, m_y1, m_recv, m_recv); end
    end
  endtask

  task automatic test_reset_drain();
    do_reset();
    ready_i = 1'b0;
    for (int i = 0; i < 3; i++) tick(1'b1, 64'(200 + i));
    finalize_i = 1'b1;
    tick(1'b0, 64'd0);
    finalize_i = 1'b0;
    tick(1'b0, 64'd0);
    checks++; if (valid_o !== 1'b1 || done_o !== 1'b0 || rx_count_o !== 32'd3) begin
      errs++; $display("FAIL drain_hold: got v=%0b d=%0b c=%0d want 1 0 3", valid_o, done_o, rx_count_o); end
    #2 rstn_i = 1'b0;
    #1;
    checks++; if (valid_o !== 1'b0 || rx_count_o !== 32'd0) begin
      errs++; $display("FAIL async_reset: got v=%0b c=%0d want 0 0", valid_o, rx_count_o); end
    do_reset();
    checks++; if (rx_count_o !== 32'd0 || overflow_o !== 1'b0 || done_o !== 1'b0) begin
      errs++; $display("FAIL post_reset: got c=%0d o=%0b d=%0b want 0 0 0", rx_count_o, overflow_o, done_o); end
    ready_i = 1'b1;
    tick(1'b1, 64'd55);
    tick(1'b0, 64'd0);
    checks++; if (done_o !== 1'b0 || lnk_n_final !== 0 || lnk_n_send1 !== 1 || rx_count_o !== 32'd1) begin
      errs++; $display("FAIL run_after_reset: got d=%0b fin=%0d y1=%0d c=%0d want 0 0 1 1",
                       done_o, lnk_n_final, lnk_n_send1, rx_count_o); end
  endtask

  task automatic test_finalize();
    int recv0, send0;
    do_reset();
    ready_i = 1'b0;
    tick(1'b1, 64'hA1);
    tick(1'b1, 64'hB2);
    finalize_i = 1'b1;
    tick(1'b0, 64'd0);
    ready_i = 1'b1;
    tick(1'b0, 64'd0);
    checks++; if (done_o !== 1'b0 || valid_o !== 1'b1 || data_o !== 64'hB2) begin
      errs++; $display("FAIL fin_pop1: got d=%0b v=%0b data=%0h want 0 1 b2", done_o, valid_o, data_o); end
    tick(1'b0, 64'd0);
    checks++; if (done_o !== 1'b1 || valid_o !== 1'b0 || lnk_n_final !== 1 || m_phase !== 2) begin
      errs++; $display("FAIL fin_done: got d=%0b v=%0b fin=%0d phase=%0d want 1 0 1 2",
                       done_o, valid_o, lnk_n_final, m_phase); end
    recv0 = lnk_n_recv;
    send0 = lnk_n_send;
    lnk_script.push_back({1'b1, 64'hC3});
    repeat (5) tick(1'b1, 64'hC3);
    checks++; if (lnk_n_recv !== recv0 || lnk_n_send !== send0 || lnk_n_final !== m_fin || lnk_script.size() !== 1) begin
      errs++; $display("FAIL done_quiet: got r=%0d s=%0d fin=%0d q=%0d want %0d %0d %0d 1",
                       lnk_n_recv, lnk_n_send, lnk_n_final, lnk_script.size(), recv0, send0, m_fin); end
    checks++; if (done_o !== 1'b1 || valid_o !== 1'b0 || lnk_n_send1 !== m_y1) begin
      errs++; $display("FAIL done_outputs: got d=%0b v=%0b y1=%0d want 1 0 %0d", done_o, valid_o, lnk_n_send1, m_y1); end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_single();
    test_overflow();
    test_back_to_back();
    test_random();
    test_reset_drain();
    test_finalize();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/mpi_rx_bridge.md
# mpi_rx_bridge

Receive end of the rank-to-rank MPI link. Each cycle it polls the remote sender through the DPI data/valid calls and buffers accepted flits in a small FIFO. It delivers them to local logic over a valid/ready handshake and returns one yummy (credit) per consumed flit through the DPI yummy call. It sits in the per-rank testbench top, facing the sender that pushes data and waits for yummies, and keeps the sender and receiver ranks in lockstep.

## Interface
- DATA_W, 64, flit width; must match the 64-bit DPI data word.
- FIFO_DEPTH, 4, buffer entries; equals the sender's credit count. Power of two, at least 2.
- clk_i  input  1  single clock.
- rstn_i  input  1  asynchronous, active-low reset.
- rank_i  input  32 (int)  local MPI rank; passed to mpi_send_yummy.
- origin_i  input  32 (int)  remote sender rank; source for mpi_receive_data and destination for yummies.
- finalize_i  input  1  request shutdown (level).
- data_o  output  DATA_W  head-of-FIFO flit.
- valid_o  output  1  data_o is valid.
- ready_i  input  1  local consumer accepts data_o.
- yummy_o  output  1  a yummy was sent on the previous edge (debug mirror).
- full_o  output  1  FIFO holds FIFO_DEPTH entries.
- overflow_o  output  1  sticky: a flit arrived while the FIFO was full with no pop.
- rx_count_o  output  32  flits accepted into the FIFO; wraps modulo 2^32.
- done_o  output  1  finalize() has been called.

## Operation
- States: RUN, DRAIN, DONE. Reset enters RUN.
- RUN and DRAIN, every posedge, in this order:
  - call mpi_receive_data(origin_i), then mpi_get_valid(); only bit 0 of the valid byte is used;
  - compute pop = valid_o && ready_i;
  - compute push = rx_valid && (!full || pop);
  - call mpi_send_yummy({7'b0,pop}, origin_i, rank_i);
  - update the FIFO.
- Exactly one receive pair and one yummy send occur per cycle, so lockstep with the sender (send data, then wait for yummy) holds. An idle cycle still sends a yummy with valid 0.
- If rx_valid && full && !pop: the flit is dropped, overflow_o is set and rx_count_o does not increment.
- rx_count_o increments by 1 on every push.
- RUN goes to DRAIN when finalize_i=1.
- DRAIN goes to DONE on the first edge where the FIFO is empty after the update and rx_valid=0 was polled. finalize() is called once, on that edge.
- DONE makes no DPI calls. done_o=1, valid_o=0. finalize_i is ignored.
- FIFO order is strict; data_o is stable while valid_o && !ready_i.
- The block does not call initialize(); the top does that before reset is released.

## Timing
- Reset values: data_o=0, valid_o=0, yummy_o=0, full_o=0, overflow_o=0, rx_count_o=0, done_o=0. Pointers are cleared and the state is RUN.
- No DPI calls while rstn_i=0.
- Latency: a flit polled at edge N drives valid_o/data_o after edge N (1 cycle), if the FIFO was empty.
- A pop at edge N is reported to the sender in that edge's mpi_send_yummy call. yummy_o is high after edge N.
- Push and pop on the same edge: the count is unchanged, including when the FIFO is full.
- Pointers wrap modulo FIFO_DEPTH. Full and empty are distinguished by an extra pointer bit.
- Reset mid-RUN or mid-DRAIN: the FIFO is flushed and the state returns to RUN; the sender must be reset in the same cycle.
- Reset after DONE is illegal (MPI is finalized). An assertion fires.

## Structure
- mpi_bridge_pkg holds:
  - the DPI-C imports (mpi_receive_data, mpi_get_valid, mpi_send_yummy, finalize);
  - the localparam DATA_W_DEFAULT=64;
  - the state enum rx_state_e {RUN, DRAIN, DONE}.
- Sub-module mpi_rx_fifo: a synchronous FIFO with push/pop/full/empty/head outputs. It contains no DPI calls; the bridge owns all DPI calls and the FSM.

## Test plan
The bench uses a C DPI stub that scripts incoming flits and logs every call.
- Reset held for 5 cycles -> all outputs 0, zero DPI calls logged; after release, one receive pair and one send per cycle.
- Flit 0x00000000DEADBEEF with valid at edge 1, ready_i=1 -> valid_o and data_o=0x...DEADBEEF after edge 1; the edge-2 send carries valid 1; rx_count_o=1.
- ready_i=0 with 5 consecutive flits 1..5 -> full_o after the 4th, flit 5 dropped, overflow_o=1, rx_count_o=4. Then ready_i=1 -> 1,2,3,4 delivered in order with 4 yummies of valid 1.
- FIFO full with ready_i=1 and a flit arriving every cycle for 10 cycles -> full_o stays 1, overflow_o=0, one yummy per cycle, rx_count_o=+10.
- finalize_i with 2 entries buffered and the sender idle, ready_i=1 -> DRAIN for 2 pops, then DONE; finalize() logged exactly once, done_o=1, no further DPI calls.
- Reset asserted mid-DRAIN with 3 entries -> valid_o=0 immediately (asynchronous), state RUN after release, rx_count_o=0, overflow_o=0.
